// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
//   Single-bus register-transfer datapath for the Mini-SRC CPU. An external
//   control unit drives one set of load enables and a bus source select each
//   cycle. Every register input is fed from the one shared bus. The ALU forms a
//   double-width result from Y (operand A) and the bus (operand B) and writes it
//   into Z.
//
// Ports
//   clock          rising-edge clock
//   clear          asynchronous active-low reset, zeroes every register
//   incPC          ALU override: Zlow = bus + 1, Zhigh = 0
//   GP_addr        destination index for general-purpose writes (e_GP)
//   Mdatain        memory read data, selected into MDR when MDR_read = 1
//   MDR_read       MDR source: 1 = Mdatain, 0 = bus
//   e_PC/e_IR/e_Y  load PC / IR / Y from the bus
//   e_Z            load Z from the ALU result
//   e_HI/e_LO      load HI / LO from the bus
//   e_MDR          load MDR from Mdatain or the bus
//   e_MAR          load MAR from the bus
//   e_GP           load R[GP_addr] from the bus
//   ALU_op         ALU operation select
//   BusDataSelect  bus source: 0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow,
//                  20 PC, 21 MDR, 22-31 zero
//   bus_out        current bus value (combinational)
//   MAR_out        MAR register
//   IR_out         IR register
//   Z_out          Z register {Zhigh, Zlow}
// -----------------------------------------------------------------------------
module datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               incPC,
    input  logic [3:0]         GP_addr,
    input  logic [WIDTH-1:0]   Mdatain,
    input  logic               MDR_read,
    input  logic               e_PC,
    input  logic               e_IR,
    input  logic               e_Y,
    input  logic               e_Z,
    input  logic               e_HI,
    input  logic               e_LO,
    input  logic               e_MDR,
    input  logic               e_MAR,
    input  logic               e_GP,
    input  logic [3:0]         ALU_op,
    input  logic [4:0]         BusDataSelect,
    output logic [WIDTH-1:0]   bus_out,
    output logic [WIDTH-1:0]   MAR_out,
    output logic [WIDTH-1:0]   IR_out,
    output logic [2*WIDTH-1:0] Z_out
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SHR  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_ROR  = 4'b0110;
    localparam logic [3:0] OP_ROL  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_NEG  = 4'b1010;
    localparam logic [3:0] OP_NOT  = 4'b1011;
    localparam logic [3:0] OP_SHRA = 4'b1100;
    localparam logic [3:0] OP_PA0  = 4'b1101;
    localparam logic [3:0] OP_PA1  = 4'b1110;
    localparam logic [3:0] OP_PA2  = 4'b1111;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    // Most negative word; dividing it by -1 overflows and is pinned below.
    localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

    // Register state
    logic [WIDTH-1:0]   gp_q [16];
    logic [WIDTH-1:0]   gp_d [16];
    logic [WIDTH-1:0]   pc_q,  pc_d;
    logic [WIDTH-1:0]   ir_q,  ir_d;
    logic [WIDTH-1:0]   mar_q, mar_d;
    logic [WIDTH-1:0]   mdr_q, mdr_d;
    logic [WIDTH-1:0]   y_q,   y_d;
    logic [2*WIDTH-1:0] z_q,   z_d;
    logic [WIDTH-1:0]   hi_q,  hi_d;
    logic [WIDTH-1:0]   lo_q,  lo_d;

    // Combinational datapath
    logic [WIDTH-1:0]        bus_s;
    logic [2*WIDTH-1:0]      alu_s;
    logic [4:0]              sh_s;
    logic [2*WIDTH-1:0]      dbl_s;
    logic [2*WIDTH-1:0]      ror_s;
    logic [2*WIDTH-1:0]      rol_s;
    logic [2*WIDTH-1:0]      a_ext_s;
    logic [2*WIDTH-1:0]      b_ext_s;
    logic [2*WIDTH-1:0]      prod_s;
    logic [WIDTH-1:0]        sra_s;
    logic signed [WIDTH-1:0] quo_s;
    logic signed [WIDTH-1:0] rem_s;

    // Bus source multiplexer: general registers in the lower half of the select space
    always_comb begin
        bus_s = ZERO_W;
        if (BusDataSelect[4] == 1'b0) begin
            bus_s = gp_q[BusDataSelect[3:0]];
        end else begin
            case (BusDataSelect[3:0])
                4'd0:    bus_s = hi_q;
                4'd1:    bus_s = lo_q;
                4'd2:    bus_s = z_q[2*WIDTH-1:WIDTH];
                4'd3:    bus_s = z_q[WIDTH-1:0];
                4'd4:    bus_s = pc_q;
                4'd5:    bus_s = mdr_q;
                default: bus_s = ZERO_W;
            endcase
        end
    end

    // Shift, rotate and multiply helpers shared by the ALU
    always_comb begin
        sh_s    = bus_s[4:0];
        // Rotations fall out of shifting a doubled copy of A.
        dbl_s   = {y_q, y_q};
        ror_s   = dbl_s >> sh_s;
        rol_s   = dbl_s << sh_s;
        sra_s   = $signed(y_q) >>> sh_s;
        // Sign-extended operands make the low 2*WIDTH bits of an unsigned
        // product equal to the signed product.
        a_ext_s = {{WIDTH{y_q[WIDTH-1]}}, y_q};
        b_ext_s = {{WIDTH{bus_s[WIDTH-1]}}, bus_s};
        prod_s  = a_ext_s * b_ext_s;
    end

    // Signed divider; zero divisor and MIN / -1 are resolved explicitly
    always_comb begin
        quo_s = ZERO_W;
        rem_s = ZERO_W;
        if (bus_s == ZERO_W) begin
            quo_s = ONES_W;
            rem_s = y_q;
        end else if ((y_q == MIN_W) && (bus_s == ONES_W)) begin
            quo_s = MIN_W;
            rem_s = ZERO_W;
        end else begin
            quo_s = $signed(y_q) / $signed(bus_s);
            rem_s = $signed(y_q) % $signed(bus_s);
        end
    end

    // ALU result selection; incPC takes priority over ALU_op
    always_comb begin
        alu_s = {ZERO_W, ZERO_W};
        if (incPC) begin
            alu_s = {ZERO_W, bus_s + ONE_W};
        end else begin
            case (ALU_op)
                OP_ADD:  alu_s = {ZERO_W, y_q + bus_s};
                OP_SUB:  alu_s = {ZERO_W, y_q - bus_s};
                OP_AND:  alu_s = {ZERO_W, y_q & bus_s};
                OP_OR:   alu_s = {ZERO_W, y_q | bus_s};
                OP_SHR:  alu_s = {ZERO_W, y_q >> sh_s};
                OP_SHL:  alu_s = {ZERO_W, y_q << sh_s};
                OP_ROR:  alu_s = {ZERO_W, ror_s[WIDTH-1:0]};
                OP_ROL:  alu_s = {ZERO_W, rol_s[2*WIDTH-1:WIDTH]};
                OP_MUL:  alu_s = prod_s;
                OP_DIV:  alu_s = {rem_s, quo_s};
                OP_NEG:  alu_s = {ZERO_W, ZERO_W - bus_s};
                OP_NOT:  alu_s = {ZERO_W, ~bus_s};
                OP_SHRA: alu_s = {ZERO_W, sra_s};
                OP_PA0:  alu_s = {ZERO_W, bus_s};
                OP_PA1:  alu_s = {ZERO_W, bus_s};
                OP_PA2:  alu_s = {ZERO_W, bus_s};
                default: alu_s = {ZERO_W, bus_s};
            endcase
        end
    end

    // Next-state for every register: load from bus (or ALU / Mdatain) when enabled
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            gp_d[i] = gp_q[i];
        end
        if (e_GP) begin
            gp_d[GP_addr] = bus_s;
        end else begin
            gp_d[GP_addr] = gp_q[GP_addr];
        end

        if (e_PC) begin
            pc_d = bus_s;
        end else begin
            pc_d = pc_q;
        end

        if (e_IR) begin
            ir_d = bus_s;
        end else begin
            ir_d = ir_q;
        end

        if (e_MAR) begin
            mar_d = bus_s;
        end else begin
            mar_d = mar_q;
        end

        if (e_MDR) begin
            mdr_d = MDR_read ? Mdatain : bus_s;
        end else begin
            mdr_d = mdr_q;
        end

        if (e_Y) begin
            y_d = bus_s;
        end else begin
            y_d = y_q;
        end

        if (e_Z) begin
            z_d = alu_s;
        end else begin
            z_d = z_q;
        end

        if (e_HI) begin
            hi_d = bus_s;
        end else begin
            hi_d = hi_q;
        end

        if (e_LO) begin
            lo_d = bus_s;
        end else begin
            lo_d = lo_q;
        end
    end

    // Register bank update with asynchronous clear
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) begin
                gp_q[i] <= ZERO_W;
            end
            pc_q  <= ZERO_W;
            ir_q  <= ZERO_W;
            mar_q <= ZERO_W;
            mdr_q <= ZERO_W;
            y_q   <= ZERO_W;
            z_q   <= {ZERO_W, ZERO_W};
            hi_q  <= ZERO_W;
            lo_q  <= ZERO_W;
        end else begin
            for (int i = 0; i < 16; i++) begin
                gp_q[i] <= gp_d[i];
            end
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign bus_out = bus_s;
    assign MAR_out = mar_q;
    assign IR_out  = ir_q;
    assign Z_out   = z_q;

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath
//   Self-checking bench for datapath. Register expectations are queued when a
//   transfer is driven and compared one edge later; bus values are checked
//   directly while the select is held. ALU expectations come from constants
//   and from an independent bit-level reference model.
// -----------------------------------------------------------------------------
module tb_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic        incPC;
    logic [3:0]  GP_addr;
    logic [31:0] Mdatain;
    logic        MDR_read;
    logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
    logic [3:0]  ALU_op;
    logic [4:0]  BusDataSelect;
    logic [31:0] bus_out;
    logic [31:0] MAR_out;
    logic [31:0] IR_out;
    logic [63:0] Z_out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] SRC_BUS = 2'd0;
    localparam logic [1:0] SRC_Z   = 2'd1;
    localparam logic [1:0] SRC_MAR = 2'd2;
    localparam logic [1:0] SRC_IR  = 2'd3;

    typedef struct packed {
        logic [1:0]   src;
        logic [63:0]  exp;
        logic [127:0] tag;
    } sb_t;

    sb_t sb_q[$];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [63:0] exp;
    } vec_t;

    datapath dut (
        .clock         (clock),
        .clear         (clear),
        .incPC         (incPC),
        .GP_addr       (GP_addr),
        .Mdatain       (Mdatain),
        .MDR_read      (MDR_read),
        .e_PC          (e_PC),
        .e_IR          (e_IR),
        .e_Y           (e_Y),
        .e_Z           (e_Z),
        .e_HI          (e_HI),
        .e_LO          (e_LO),
        .e_MDR         (e_MDR),
        .e_MAR         (e_MAR),
        .e_GP          (e_GP),
        .ALU_op        (ALU_op),
        .BusDataSelect (BusDataSelect),
        .bus_out       (bus_out),
        .MAR_out       (MAR_out),
        .IR_out        (IR_out),
        .Z_out         (Z_out)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [1:0] src, input logic [127:0] tag, input logic [63:0] exp);
        sb_t e;
        e.src = src;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    function automatic logic [63:0] observe(input logic [1:0] src);
        case (src)
            SRC_BUS: return {32'h0, bus_out};
            SRC_Z:   return Z_out;
            SRC_MAR: return {32'h0, MAR_out};
            SRC_IR:  return {32'h0, IR_out};
            default: return 64'h0;
        endcase
    endfunction

    task automatic idle();
        incPC = 1'b0; GP_addr = 4'd0; MDR_read = 1'b0;
        e_PC = 1'b0; e_IR = 1'b0; e_Y = 1'b0; e_Z = 1'b0; e_HI = 1'b0;
        e_LO = 1'b0; e_MDR = 1'b0; e_MAR = 1'b0; e_GP = 1'b0;
        ALU_op = 4'd0; BusDataSelect = 5'd0;
    endtask

    // Advance one edge, then drain the scoreboard against the outputs.
    task automatic tick();
        sb_t e;
        @(posedge clock);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq($sformatf("%0s", e.tag), observe(e.src), e.exp);
        end
        idle();
    endtask

    task automatic peek_bus(input logic [4:0] sel, input string tag, input logic [31:0] exp);
        BusDataSelect = sel;
        #1;
        check_eq(tag, {32'h0, bus_out}, {32'h0, exp});
    endtask

    task automatic load_gp(input logic [3:0] n, input logic [31:0] v);
        Mdatain = v; MDR_read = 1'b1; e_MDR = 1'b1;
        tick();
        BusDataSelect = 5'd21; e_GP = 1'b1; GP_addr = n;
        tick();
    endtask

    task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input logic inc, input logic [63:0] exp, input logic [127:0] tag);
        load_gp(4'd1, a);
        load_gp(4'd2, b);
        BusDataSelect = 5'd1; e_Y = 1'b1;
        tick();
        BusDataSelect = 5'd2; ALU_op = op; incPC = inc; e_Z = 1'b1;
        expect_out(SRC_Z, tag, exp);
        tick();
    endtask

    // Reference ALU written bit-serially / by magnitudes.
    function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic inc);
        logic [31:0] r;
        logic [31:0] ua, ub, q, m;
        longint sa, sb;
        int sh;
        sh = int'(b[4:0]);
        r = a;
        if (inc) return {32'h0, b + 32'd1};
        case (op)
            4'd0: return {32'h0, a + b};
            4'd1: return {32'h0, a + ~b + 32'd1};
            4'd2: return {32'h0, a & b};
            4'd3: return {32'h0, a | b};
            4'd4: begin for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]}; return {32'h0, r}; end
            4'd5: begin for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0}; return {32'h0, r}; end
            4'd6: begin for (int i = 0; i < sh; i++) r = {r[0], r[31:1]}; return {32'h0, r}; end
            4'd7: begin for (int i = 0; i < sh; i++) r = {r[30:0], r[31]}; return {32'h0, r}; end
            4'd8: begin sa = $signed(a); sb = $signed(b); return sa * sb; end
            4'd9: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                ua = a[31] ? (32'h0 - a) : a;
                ub = b[31] ? (32'h0 - b) : b;
                q = ua / ub;
                m = ua % ub;
                if (a[31] ^ b[31]) q = 32'h0 - q;
                if (a[31]) m = 32'h0 - m;
                return {m, q};
            end
            4'd10: return {32'h0, 32'h0 - b};
            4'd11: return {32'h0, ~b};
            4'd12: begin for (int i = 0; i < sh; i++) r = {r[31], r[31:1]}; return {32'h0, r}; end
            default: return {32'h0, b};
        endcase
    endfunction

    vec_t vecs[9];

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;

        vecs[0] = '{32'hFFFFFFFA, 32'd7, 4'd8,  64'hFFFFFFFF_FFFFFFD6};
        vecs[1] = '{32'hFFFFFFFA, 32'd7, 4'd9,  64'hFFFFFFFA_00000000};
        vecs[2] = '{32'hFFFFFFFA, 32'd0, 4'd9,  64'hFFFFFFFA_FFFFFFFF};
        vecs[3] = '{32'h80000001, 32'd1, 4'd4,  64'h00000000_40000000};
        vecs[4] = '{32'h80000001, 32'd1, 4'd5,  64'h00000000_00000002};
        vecs[5] = '{32'h80000001, 32'd1, 4'd6,  64'h00000000_C0000000};
        vecs[6] = '{32'h80000001, 32'd1, 4'd7,  64'h00000000_00000003};
        vecs[7] = '{32'h80000001, 32'd1, 4'd12, 64'h00000000_C0000000};
        vecs[8] = '{32'hFFFFFFFF, 32'd1, 4'd0,  64'h00000000_00000000};

        Mdatain = 32'h0;
        idle();
        clear = 1'b0;
        #2;
        check_eq("rst_z",   Z_out, 64'h0);
        check_eq("rst_mar", {32'h0, MAR_out}, 64'h0);
        check_eq("rst_ir",  {32'h0, IR_out}, 64'h0);
        peek_bus(5'd0,  "rst_bus_r0", 32'h0);
        peek_bus(5'd20, "rst_bus_pc", 32'h0);
        peek_bus(5'd21, "rst_bus_mdr", 32'h0);
        idle();
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;

        // Instruction fetch from PC = 0.
        BusDataSelect = 5'd20; e_MAR = 1'b1; incPC = 1'b1; e_Z = 1'b1;
        expect_out(SRC_MAR, "fetch_mar", 64'h0);
        expect_out(SRC_Z,   "fetch_z",   64'h1);
        tick();
        BusDataSelect = 5'd19; e_PC = 1'b1;
        MDR_read = 1'b1; e_MDR = 1'b1; Mdatain = 32'h2A318000;
        tick();
        BusDataSelect = 5'd21; e_IR = 1'b1;
        expect_out(SRC_IR, "fetch_ir", 64'h2A318000);
        tick();
        peek_bus(5'd20, "fetch_pc", 32'h1);
        idle();

        // SHRA scenario through the register file.
        load_gp(4'd3, 32'hFFFFFF88);
        load_gp(4'd7, 32'd2);
        BusDataSelect = 5'd3; e_Y = 1'b1;
        tick();
        BusDataSelect = 5'd7; ALU_op = 4'b1100; e_Z = 1'b1;
        expect_out(SRC_Z, "shra_z", 64'h00000000_FFFFFFE2);
        tick();
        BusDataSelect = 5'd19; e_GP = 1'b1; GP_addr = 4'd4;
        tick();
        peek_bus(5'd4, "shra_r4", 32'hFFFFFFE2);
        idle();

        // Constant ALU vectors.
        foreach (vecs[i]) begin
            alu_run(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, vecs[i].exp, "alu_vec");
        end

        // Boundary cases against the reference model.
        alu_run(32'hFFFFFFF9, 32'd2,        4'd9,  1'b0, ref_alu(32'hFFFFFFF9, 32'd2, 4'd9, 1'b0), "div_neg");
        alu_run(32'h80000000, 32'hFFFFFFFF, 4'd9,  1'b0, ref_alu(32'h80000000, 32'hFFFFFFFF, 4'd9, 1'b0), "div_ovf");
        alu_run(32'h12345678, 32'd0,        4'd6,  1'b0, ref_alu(32'h12345678, 32'd0, 4'd6, 1'b0), "ror_zero");
        alu_run(32'h12345678, 32'd33,       4'd5,  1'b0, ref_alu(32'h12345678, 32'd33, 4'd5, 1'b0), "shl_b40");
        alu_run(32'h00000005, 32'h00000007, 4'd1,  1'b0, ref_alu(32'd5, 32'd7, 4'd1, 1'b0), "sub_wrap");
        alu_run(32'h0,        32'hFFFFFFFF, 4'd8,  1'b1, 64'h0, "inc_wrap");
        alu_run(32'h0,        32'd5,        4'd9,  1'b1, 64'h6, "inc_over");
        alu_run(32'hDEAD0000, 32'hCAFEF00D, 4'd15, 1'b0, 64'h00000000_CAFEF00D, "pass");

        // Randomised sweep of every opcode.
        for (int k = 0; k < 16; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 4'(k);
            alu_run(ra, rb, rop, 1'b0, ref_alu(ra, rb, rop, 1'b0), "alu_rand");
        end

        // Several enables in one cycle all capture the same bus value.
        load_gp(4'd5, 32'hA5A50F0F);
        BusDataSelect = 5'd5; e_HI = 1'b1; e_LO = 1'b1; e_MAR = 1'b1;
        e_GP = 1'b1; GP_addr = 4'd8;
        expect_out(SRC_MAR, "multi_mar", 64'hA5A50F0F);
        tick();
        peek_bus(5'd16, "multi_hi", 32'hA5A50F0F);
        peek_bus(5'd17, "multi_lo", 32'hA5A50F0F);
        peek_bus(5'd8,  "multi_r8", 32'hA5A50F0F);
        idle();

        // MDR loaded from the bus with HI as source; unused selects read 0.
        load_gp(4'd11, 32'h12345678);
        BusDataSelect = 5'd11; e_HI = 1'b1;
        tick();
        BusDataSelect = 5'd16; MDR_read = 1'b0; e_MDR = 1'b1; Mdatain = 32'hFFFF0000;
        tick();
        peek_bus(5'd21, "mdr_bus", 32'h12345678);
        peek_bus(5'd22, "sel22",   32'h0);
        peek_bus(5'd31, "sel31",   32'h0);
        idle();

        // Asynchronous clear in the middle of a cycle, with loads requested.
        @(posedge clock);
        #3;
        BusDataSelect = 5'd16; e_MAR = 1'b1; e_IR = 1'b1;
        clear = 1'b0;
        #1;
        check_eq("mid_z",   Z_out, 64'h0);
        check_eq("mid_mar", {32'h0, MAR_out}, 64'h0);
        check_eq("mid_ir",  {32'h0, IR_out}, 64'h0);
        @(posedge clock);
        #1;
        check_eq("mid_abort", {32'h0, MAR_out}, 64'h0);
        idle();
        for (int s = 0; s < 22; s += 3) begin
            peek_bus(5'(s), "mid_bus", 32'h0);
        end
        @(negedge clock);
        clear = 1'b1;
        idle();
        @(posedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
